// File: rtl/mips_min_sopc_if.sv
// Instruction fetch bus between the core pipeline and the instruction ROM.
//   ce   : fetch enable (master -> slave)
//   addr : byte address of the instruction, i.e. the pc (master -> slave)
//   inst : combinational instruction word, 0 when not fetching (slave -> master)
interface mips_min_sopc_if;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;

  modport master (output ce, output addr, input inst);
  modport slave  (input ce, input addr, output inst);
endinterface

// File: rtl/mips_min_sopc.sv
// Minimal MIPS32 SoC: 5-stage in-order pipeline (IF, ID, EX, MEM, WB) running
// the logic/shift/LUI/no-op subset out of an on-chip instruction ROM.
//   mips_min_sopc : clk (rising-edge clock), rst (synchronous, active-low reset)
//   openmips      : clk, rst; owns the ROM (inst_rom0) and GPRs (regfile1)
//   inst_rom      : bus (fetch slave); contents preloaded through inst_mem
//   regfile       : clk_i, rst_i, one write port, two write-through read ports

module inst_rom #(
  parameter int unsigned INST_MEM_DEPTH = 1024
) (
  mips_min_sopc_if.slave bus
);
  localparam int unsigned AW = $clog2(INST_MEM_DEPTH);

  logic [31:0] inst_mem [0:INST_MEM_DEPTH-1];

  // Out-of-range covers both high address bits and a misaligned byte offset.
  always_comb begin
    bus.inst = '0;
    if (bus.ce && (bus.addr[31:AW+2] == '0) && (bus.addr[1:0] == 2'b00))
      bus.inst = inst_mem[bus.addr[AW+1:2]];
  end
endmodule

module regfile #(
  parameter int unsigned REG_NUM = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o
);
  logic [31:0] regs [0:REG_NUM-1];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    if (raddr1_i != 5'd0)
      rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs[raddr1_i];
  end

  always_comb begin
    rdata2_o = '0;
    if (raddr2_i != 5'd0)
      rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs[raddr2_i];
  end
endmodule

module openmips #(
  parameter int unsigned INST_MEM_DEPTH = 1024,
  parameter int unsigned REG_NUM        = 32
) (
  input logic clk,
  input logic rst
);
  typedef enum logic [2:0] {OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA} alu_op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000, OPC_ANDI = 6'b001100,
                         OPC_ORI     = 6'b001101, OPC_XORI = 6'b001110,
                         OPC_LUI     = 6'b001111;
  localparam logic [5:0] F_AND = 6'b100100, F_OR  = 6'b100101, F_XOR  = 6'b100110,
                         F_NOR = 6'b100111, F_SLLV = 6'b000100, F_SRLV = 6'b000110,
                         F_SRAV = 6'b000111, F_SLL = 6'b000000, F_SRL  = 6'b000010,
                         F_SRA = 6'b000011;

  mips_min_sopc_if rom_bus ();

  // IF
  logic [31:0] pc_q;
  logic        ce_q;
  logic [31:0] if_id_inst_d, if_id_inst_q;

  // ID/EX, EX/MEM, MEM/WB
  alu_op_e     id_ex_op_d, id_ex_op_q;
  logic [31:0] id_ex_s1_d, id_ex_s1_q, id_ex_s2_d, id_ex_s2_q;
  logic [4:0]  id_ex_wd_d, id_ex_wd_q;
  logic        id_ex_wen, id_ex_wreg_d, id_ex_wreg_q;
  logic [31:0] ex_mem_wdata_d, ex_mem_wdata_q;
  logic [4:0]  ex_mem_wd_q, mem_wb_wd_q;
  logic        ex_mem_wreg_q, mem_wb_wreg_q;
  logic [31:0] mem_wb_wdata_q;

  logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;

  assign rom_bus.ce   = ce_q;
  assign rom_bus.addr = pc_q;
  assign if_id_inst_d = rom_bus.inst;

  inst_rom #(.INST_MEM_DEPTH(INST_MEM_DEPTH)) inst_rom0 (.bus(rom_bus));

  regfile #(.REG_NUM(REG_NUM)) regfile1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (mem_wb_wreg_q),
    .waddr_i  (mem_wb_wd_q),
    .wdata_i  (mem_wb_wdata_q),
    .raddr1_i (if_id_inst_q[25:21]),
    .rdata1_o (rf_rdata1),
    .raddr2_i (if_id_inst_q[20:16]),
    .rdata2_o (rf_rdata2)
  );

  // pc holds at 0 for the first enabled cycle so address 0 is fetched once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= '0;
      ce_q <= 1'b0;
    end else begin
      ce_q <= 1'b1;
      if (ce_q) pc_q <= pc_q + 32'd4;
    end
  end

  // Operand forwarding: EX result beats MEM result beats register file.
  // Destinations of $0 never carry wreg, so $0 is never forwarded.
  always_comb begin
    rs_val = rf_rdata1;
    if (id_ex_wreg_q && (id_ex_wd_q == if_id_inst_q[25:21]))         rs_val = ex_mem_wdata_d;
    else if (ex_mem_wreg_q && (ex_mem_wd_q == if_id_inst_q[25:21]))  rs_val = ex_mem_wdata_q;
    rt_val = rf_rdata2;
    if (id_ex_wreg_q && (id_ex_wd_q == if_id_inst_q[20:16]))         rt_val = ex_mem_wdata_d;
    else if (ex_mem_wreg_q && (ex_mem_wd_q == if_id_inst_q[20:16]))  rt_val = ex_mem_wdata_q;
  end

  // Decode; anything unrecognised (SYNC, PREF, undefined) leaves wen low.
  always_comb begin
    id_ex_op_d = OP_OR;
    id_ex_s1_d = '0;
    id_ex_s2_d = '0;
    id_ex_wd_d = '0;
    id_ex_wen  = 1'b0;
    case (if_id_inst_q[31:26])
      OPC_SPECIAL: begin
        id_ex_wd_d = if_id_inst_q[15:11];
        id_ex_s1_d = rs_val;
        id_ex_s2_d = rt_val;
        case (if_id_inst_q[5:0])
          F_AND:  begin id_ex_op_d = OP_AND; id_ex_wen = 1'b1; end
          F_OR:   begin id_ex_op_d = OP_OR;  id_ex_wen = 1'b1; end
          F_XOR:  begin id_ex_op_d = OP_XOR; id_ex_wen = 1'b1; end
          F_NOR:  begin id_ex_op_d = OP_NOR; id_ex_wen = 1'b1; end
          F_SLLV: begin id_ex_op_d = OP_SLL; id_ex_wen = 1'b1; end
          F_SRLV: begin id_ex_op_d = OP_SRL; id_ex_wen = 1'b1; end
          F_SRAV: begin id_ex_op_d = OP_SRA; id_ex_wen = 1'b1; end
          F_SLL:  begin id_ex_op_d = OP_SLL; id_ex_wen = 1'b1; id_ex_s1_d = {27'd0, if_id_inst_q[10:6]}; end
          F_SRL:  begin id_ex_op_d = OP_SRL; id_ex_wen = 1'b1; id_ex_s1_d = {27'd0, if_id_inst_q[10:6]}; end
          F_SRA:  begin id_ex_op_d = OP_SRA; id_ex_wen = 1'b1; id_ex_s1_d = {27'd0, if_id_inst_q[10:6]}; end
          default: ;
        endcase
      end
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        id_ex_wd_d = if_id_inst_q[20:16];
        id_ex_s1_d = rs_val;
        id_ex_s2_d = {16'd0, if_id_inst_q[15:0]};
        id_ex_wen  = 1'b1;
        case (if_id_inst_q[27:26])
          2'b00:   id_ex_op_d = OP_AND;
          2'b01:   id_ex_op_d = OP_OR;
          default: id_ex_op_d = OP_XOR;
        endcase
      end
      OPC_LUI: begin
        id_ex_wd_d = if_id_inst_q[20:16];
        id_ex_s1_d = {if_id_inst_q[15:0], 16'd0};
        id_ex_wen  = 1'b1;
      end
      default: ;
    endcase
    id_ex_wreg_d = id_ex_wen && (id_ex_wd_d != 5'd0);
  end

  always_comb begin
    ex_mem_wdata_d = '0;
    case (id_ex_op_q)
      OP_AND:  ex_mem_wdata_d = id_ex_s1_q & id_ex_s2_q;
      OP_OR:   ex_mem_wdata_d = id_ex_s1_q | id_ex_s2_q;
      OP_XOR:  ex_mem_wdata_d = id_ex_s1_q ^ id_ex_s2_q;
      OP_NOR:  ex_mem_wdata_d = ~(id_ex_s1_q | id_ex_s2_q);
      OP_SLL:  ex_mem_wdata_d = id_ex_s2_q << id_ex_s1_q[4:0];
      OP_SRL:  ex_mem_wdata_d = id_ex_s2_q >> id_ex_s1_q[4:0];
      OP_SRA:  ex_mem_wdata_d = $signed(id_ex_s2_q) >>> id_ex_s1_q[4:0];
      default: ;
    endcase
  end

  // MEM has no memory access in this subset; it is a pure pipeline stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_id_inst_q   <= '0;
      id_ex_op_q     <= OP_OR;
      id_ex_s1_q     <= '0;
      id_ex_s2_q     <= '0;
      id_ex_wd_q     <= '0;
      id_ex_wreg_q   <= 1'b0;
      ex_mem_wd_q    <= '0;
      ex_mem_wreg_q  <= 1'b0;
      ex_mem_wdata_q <= '0;
      mem_wb_wd_q    <= '0;
      mem_wb_wreg_q  <= 1'b0;
      mem_wb_wdata_q <= '0;
    end else begin
      if_id_inst_q   <= if_id_inst_d;
      id_ex_op_q     <= id_ex_op_d;
      id_ex_s1_q     <= id_ex_s1_d;
      id_ex_s2_q     <= id_ex_s2_d;
      id_ex_wd_q     <= id_ex_wd_d;
      id_ex_wreg_q   <= id_ex_wreg_d;
      ex_mem_wd_q    <= id_ex_wd_q;
      ex_mem_wreg_q  <= id_ex_wreg_q;
      ex_mem_wdata_q <= ex_mem_wdata_d;
      mem_wb_wd_q    <= ex_mem_wd_q;
      mem_wb_wreg_q  <= ex_mem_wreg_q;
      mem_wb_wdata_q <= ex_mem_wdata_q;
    end
  end
endmodule

module mips_min_sopc #(
  parameter int unsigned INST_MEM_DEPTH = 1024,
  parameter int unsigned REG_NUM        = 32
) (
  input logic clk,
  input logic rst
);
  openmips #(.INST_MEM_DEPTH(INST_MEM_DEPTH), .REG_NUM(REG_NUM)) openmips0 (
    .clk (clk),
    .rst (rst)
  );
endmodule

// File: tb/tb_mips_min_sopc.sv
// Directed bench for mips_min_sopc: preloads the ROM, releases reset and
// checks every GPR plus the fetch bus after each rising edge against a
// hand-computed timeline; then repeats the run after a one-edge reset.
module tb_mips_min_sopc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] prog [0:24];

  mips_min_sopc_if mon_if ();

  mips_min_sopc dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  assign mon_if.ce   = dut.openmips0.ce_q;
  assign mon_if.addr = dut.openmips0.pc_q;
  assign mon_if.inst = dut.openmips0.if_id_inst_d;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // $2 after n edges with rst=1.
  function automatic logic [31:0] exp_r2(int n);
    if (n < 6)  return 32'h0;
    if (n == 6) return 32'h04040000;
    if (n <= 11) return 32'h04040404;
    case (n)
      12: return 32'h04040400;
      13: return 32'h02020000;
      14: return 32'h00020200;
      15, 16, 17: return 32'h00001010;
      18, 19: return 32'h80800000;
      20: return 32'hffff8080;
      default: return 32'hffffff80;
    endcase
  endfunction

  function automatic logic [31:0] exp_reg(int r, int n);
    case (r)
      2:  return exp_r2(n);
      7:  return (n >= 8)  ? 32'h7 : 32'h0;
      5:  return (n >= 9)  ? 32'h5 : 32'h0;
      8:  return (n >= 10) ? 32'h8 : 32'h0;
      1:  return (n >= 22) ? 32'h0000ff00 : 32'h0;
      3:  return (n >= 23) ? 32'h00000f00 : 32'h0;
      4:  return (n >= 24) ? 32'h0000f000 : 32'h0;
      6:  return (n >= 25) ? 32'hffff00ff : 32'h0;
      10: return (n >= 28) ? 32'h000000aa : 32'h0;
      11: return (n >= 30) ? 32'h000000bb : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] prog_word(int i);
    return (i < 25) ? prog[i] : 32'h0;
  endfunction

  task automatic check_regs(input int n);
    for (int r = 0; r < 32; r++)
      chk($sformatf("gpr%0d_e%0d", r, n), dut.openmips0.regfile1.regs[r], exp_reg(r, n));
  endtask

  task automatic check_fetch(input int n);
    chk($sformatf("ce_e%0d", n), {31'd0, mon_if.ce}, 32'd1);
    chk($sformatf("pc_e%0d", n), mon_if.addr, 32'(4 * (n - 1)));
    chk($sformatf("inst_e%0d", n), mon_if.inst, prog_word(n - 1));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ce"}, {31'd0, mon_if.ce}, 32'd0);
    chk({tag, "_pc"}, mon_if.addr, 32'd0);
    chk({tag, "_inst"}, mon_if.inst, 32'd0);
    check_regs(0);
  endtask

  task automatic run_program();
    rst = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      check_regs(n);
      check_fetch(n);
    end
  endtask

  initial begin
    prog = '{32'h3C020404, 32'h34420404, 32'h34070007, 32'h34050005, 32'h34080008,
             32'h0000000F, 32'h00021200, 32'h00E21004, 32'h00021202, 32'h00A21006,
             32'h00000000, 32'hCC000000, 32'h000214C0, 32'h00000040, 32'h00021403,
             32'h01021007,
             32'h3401FF00, 32'h30230FF0, 32'h00232026, 32'h00203027,
             32'h34001234, 32'h00004825, 32'h340A00AA, 32'hFC000000, 32'h340B00BB};
    for (int i = 0; i < 1024; i++) dut.openmips0.inst_rom0.inst_mem[i] = 32'h0;
    for (int i = 0; i < 25; i++)   dut.openmips0.inst_rom0.inst_mem[i] = prog[i];

    rst = 1'b0;
    repeat (10) tick();
    check_reset("por");
    run_program();

    // Fresh run, then a one-edge reset right after the lui result lands.
    rst = 1'b0;
    tick();
    check_reset("rst2");
    rst = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      check_regs(n);
    end
    rst = 1'b0;
    tick();
    check_reset("midrst");
    run_program();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
